// File: rtl/mul_div_unit_div_pkg.sv
// Shared constants and types for the EX-stage divider.
package mul_div_unit_div_pkg;

    // Operand/result width the divider is built and verified for.
    localparam int DIV_WIDTH = 32;

    // MIPS funct codes; these must stay in step with the ALU control decode.
    localparam logic [5:0] FUNCT_DIV  = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU = 6'b011011;

    // Divider sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

    // True for the two funct codes that start a division.
    function automatic logic is_div_funct(input logic [5:0] funct);
        return (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_unit_div_step.sv
// One combinational restoring-division step: shift in the next dividend
// bit, trial-subtract the divisor and keep the difference when it fits.
module mul_div_unit_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             dvd_bit,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The running remainder is always below the divisor, so the shifted
    // value is below twice the divisor and the borrow out of the 33-bit
    // subtract is exactly the "shifted < divisor" compare.
    always_comb begin
        shifted  = {rem, dvd_bit};
        diff     = shifted - {1'b0, divisor};
        q_bit    = ~diff[WIDTH];
        rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/mul_div_unit_div.sv
// Multi-cycle 32-bit DIV/DIVU unit: one quotient bit per clock, quotient
// to LO, remainder to HI, with a final sign-fix cycle for signed divides.
module mul_div_unit_div
    import mul_div_unit_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       Signal,
    input  logic             start,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd;        // dividend shifts out the top, quotient shifts in the bottom
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;
    logic             qneg;
    logic             rneg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             busy_reg;
    logic             done_reg;

    logic             accept;
    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;

    // Accept decode and operand magnitudes; 0x80000000 negates to itself,
    // which is the correct unsigned magnitude.
    always_comb begin
        accept    = start && is_div_funct(Signal) &&
                    ((state == ST_IDLE) || (state == ST_DONE));
        is_signed = (Signal == FUNCT_DIV);
        a_neg     = is_signed && DataA[WIDTH-1];
        b_neg     = is_signed && DataB[WIDTH-1];
        a_mag     = a_neg ? (~DataA + 1'b1) : DataA;
        b_mag     = b_neg ? (~DataB + 1'b1) : DataB;
    end

    mul_div_unit_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem),
        .divisor  (divisor),
        .dvd_bit  (dvd[WIDTH-1]),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // Sequencer, datapath registers and HI/LO result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            dvd      <= '0;
            divisor  <= '0;
            rem      <= '0;
            qneg     <= 1'b0;
            rneg     <= 1'b0;
            hi_reg   <= '0;
            lo_reg   <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    state    <= ST_IDLE;
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                    if (accept) begin
                        if (DataB == '0) begin
                            // Divide by zero bypasses the iteration entirely.
                            state    <= ST_DONE;
                            done_reg <= 1'b1;
                            lo_reg   <= '1;
                            hi_reg   <= DataA;
                        end else begin
                            state    <= ST_CALC;
                            busy_reg <= 1'b1;
                            dvd      <= a_mag;
                            divisor  <= b_mag;
                            rem      <= '0;
                            cnt      <= '0;
                            qneg     <= a_neg ^ b_neg;
                            rneg     <= a_neg;
                        end
                    end
                end
                ST_CALC: begin
                    rem <= rem_next;
                    dvd <= {dvd[WIDTH-2:0], q_bit};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    lo_reg   <= qneg ? (~dvd + 1'b1) : dvd;
                    hi_reg   <= rneg ? (~rem + 1'b1) : rem;
                    state    <= ST_DONE;
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
                default: begin
                    state    <= ST_IDLE;
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule

// File: tb/tb_mul_div_unit_div.sv
// Self-checking bench for mul_div_unit_div: directed cases plus randomized
// DIV/DIVU traffic compared against a plain-arithmetic reference model.
module tb_mul_div_unit_div;

    localparam logic [5:0] F_DIV  = 6'b011010;
    localparam logic [5:0] F_DIVU = 6'b011011;
    localparam int         NORMAL_LAT = 33;  // edges from accept to the done cycle

    logic        clk;
    logic        rst_n;
    logic [5:0]  Signal;
    logic        start;
    logic [31:0] DataA;
    logic [31:0] DataB;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int          n_tests;
    int          n_fail;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;

    mul_div_unit_div dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Signal (Signal),
        .start  (start),
        .DataA  (DataA),
        .DataB  (DataB),
        .busy   (busy),
        .done   (done),
        .HI     (HI),
        .LO     (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Reference: quotient truncates toward zero, remainder takes the
    // dividend's sign; 64-bit arithmetic makes the overflow case wrap.
    function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] lo, output logic [31:0] hi);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
        end else if (f == F_DIV) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lo = 32'(sa / sb);
            hi = 32'(sa % sb);
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endfunction

    // Present a request for one cycle; operands are scrambled after the
    // accept edge to show they are not re-sampled.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Signal = f;
        DataA  = a;
        DataB  = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        DataA = $urandom;
        DataB = $urandom;
    endtask

    // Wait (bounded) for done; lat counts edges after the accept edge.
    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (!done && lat < 200) begin
            if (busy) bc++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) check_val("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input bit chk_drop);
        int lat;
        int bc;
        int exp_lat;
        issue(f, a, b);
        wait_done(lat, bc);
        model(f, a, b, exp_lo, exp_hi);
        exp_lat = (b == 32'd0) ? 0 : NORMAL_LAT;
        check_val({tag, "_lo"}, LO, exp_lo);
        check_val({tag, "_hi"}, HI, exp_hi);
        check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_val({tag, "_busy"}, 32'(bc), 32'(exp_lat));
        $display("[TB] %s f=%02h a=%08h b=%08h -> LO=%08h HI=%08h lat=%0d", tag, f, a, b, LO, HI, lat);
        if (chk_drop) begin
            @(posedge clk);
            #1;
            check_val({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        int  lat;
        int  bc;
        bit  seen;
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        Signal  = 6'd0;
        DataA   = 32'd0;
        DataB   = 32'd0;
        exp_lo  = 32'd0;
        exp_hi  = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_hi", HI, 32'd0);
        check_val("rst_lo", LO, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 1'b1);
        run_op("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op("div_7_m2", F_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1);
        run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op("divu_by0", F_DIVU, 32'd5, 32'd0, 1'b1);
        run_op("div_by0", F_DIV, 32'hFFFF_FFF0, 32'd0, 1'b1);

        // Start with a non-divide funct code is ignored
        issue(6'h20, 32'd50, 32'd5);
        check_val("bad_funct_busy", {31'd0, busy}, 32'd0);
        check_val("bad_funct_done", {31'd0, done}, 32'd0);
        check_val("bad_funct_lo", LO, exp_lo);
        check_val("bad_funct_hi", HI, exp_hi);
        $display("[TB] bad_funct start ignored busy=%0b LO=%08h HI=%08h", busy, LO, HI);

        // Start while busy is ignored; start in the DONE cycle is accepted
        issue(F_DIVU, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        issue(F_DIVU, 32'd9, 32'd3);
        check_val("ign_busy", {31'd0, busy}, 32'd1);
        wait_done(lat, bc);
        check_val("ign_lo", LO, 32'd14);
        check_val("ign_hi", HI, 32'd2);
        $display("[TB] ignored mid-op start -> LO=%08h HI=%08h", LO, HI);
        run_op("b2b_40_6", F_DIVU, 32'd40, 32'd6, 1'b1);
        check_val("b2b_lo_const", LO, 32'd6);
        check_val("b2b_hi_const", HI, 32'd4);

        // Asynchronous reset mid-operation
        issue(F_DIVU, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        check_val("pre_rst_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("arst_busy", {31'd0, busy}, 32'd0);
        check_val("arst_done", {31'd0, done}, 32'd0);
        check_val("arst_hi", HI, 32'd0);
        check_val("arst_lo", LO, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        check_val("arst_no_done", {31'd0, seen}, 32'd0);
        $display("[TB] async reset mid-op -> busy=%0b done=%0b LO=%08h HI=%08h", busy, done, LO, HI);

        // Randomized traffic, some back-to-back
        for (int i = 0; i < 60; i++) begin
            f = ($urandom_range(0, 1) == 0) ? F_DIV : F_DIVU;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                3: a = 32'h8000_0000;
                4: a = 32'($urandom_range(0, 100));
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), f, a, b, (i % 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
